// File: rtl/descale_result_fifo.sv
// descale_result_fifo: FWFT result buffer behind the multiply-descale pipe.
// In: clock, reset(n), done/FinalProduct/InsTagDescale/z_out, flush,
//   out_ready. Out: out_valid/product/tag/z, count, full, empty,
//   overflow, result_count.
module descale_result_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       FinalProduct,
  input  logic              done,
  input  logic [7:0]        InsTagDescale,
  input  logic [31:0]       z_out,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [31:0]       out_product,
  output logic [7:0]        out_tag,
  output logic [31:0]       out_z,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [15:0]       result_count
);

  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] product;
    logic [31:0] z;
  } entry_t;

  localparam logic [ADDR_W:0] FULL_C =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C =
    (ADDR_W+1)'(1);

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              push;
  logic              pop;

  assign full      = (cnt == FULL_C);
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign out_valid = ~empty;

  assign pop  = out_valid & out_ready;
  // A full queue still accepts when the head leaves this cycle.
  assign push = done & (~full | pop);

  assign head = mem[rd_ptr];

  always_comb begin
    out_product = '0;
    out_tag     = '0;
    out_z       = '0;
    if (out_valid) begin
      out_product = head.product;
      out_tag     = head.tag;
      out_z       = head.z;
    end
  end

  // Storage has no reset; empty masks stale contents.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[wr_ptr] <= '{
        tag:     InsTagDescale,
        product: FinalProduct,
        z:       z_out
      };
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      overflow     <= 1'b0;
      result_count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + ADDR_W'(1);
        result_count <= result_count + 16'd1;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + ONE_C;
        2'b01:   cnt <= cnt - ONE_C;
        default: cnt <= cnt;
      endcase
      if (done && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_descale_result_fifo.sv
// tb_descale_result_fifo: directed checks of the descale result FIFO.
// Linear stimulus, immediate assertions, one summary line.
module tb_descale_result_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] FinalProduct = '0;
  logic        done = 1'b0;
  logic [7:0]  InsTagDescale = '0;
  logic [31:0] z_out = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_product;
  logic [7:0]  out_tag;
  logic [31:0] out_z;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [15:0] result_count;

  int tests = 0;
  int fails = 0;

  descale_result_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .FinalProduct (FinalProduct),
    .done         (done),
    .InsTagDescale(InsTagDescale),
    .z_out        (z_out),
    .flush        (flush),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_product  (out_product),
    .out_tag      (out_tag),
    .out_z        (out_z),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .result_count (result_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // reset state
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_prod", out_product, 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_z", out_z, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_rc", 32'(result_count), 32'd0);
    reset = 1'b1;

    // single push then pop
    done = 1'b1;
    FinalProduct = 32'h40490FDB;
    InsTagDescale = 8'h05;
    z_out = 32'h3F800000;
    chk("t1_lat0", 32'(out_valid), 32'd0);
    step();
    done = 1'b0;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_prod", out_product, 32'h40490FDB);
    chk("t1_tag", 32'(out_tag), 32'h05);
    chk("t1_z", out_z, 32'h3F800000);
    chk("t1_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t1_valid2", 32'(out_valid), 32'd0);
    chk("t1_count2", 32'(count), 32'd0);
    chk("t1_rc", 32'(result_count), 32'd1);

    // ready while empty is harmless
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t1_rc_empty", 32'(result_count), 32'd1);

    // fill and overflow
    FinalProduct = 32'h0;
    z_out = 32'h0;
    for (int i = 0; i < 9; i++) begin
      done = 1'b1;
      InsTagDescale = 8'(i);
      step();
    end
    done = 1'b0;
    chk("t2_count", 32'(count), 32'd8);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_ovf", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain", 32'(out_tag), 32'(i));
      step();
    end
    out_ready = 1'b0;
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_rc", 32'(result_count), 32'd9);
    chk("t2_ovf_keep", 32'(overflow), 32'd1);

    // full with simultaneous push/pop
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      done = 1'b1;
      InsTagDescale = 8'(8'h10 + i);
      step();
    end
    chk("t3_full", 32'(full), 32'd1);
    done = 1'b1;
    InsTagDescale = 8'h18;
    out_ready = 1'b1;
    step();
    done = 1'b0;
    out_ready = 1'b0;
    chk("t3_count", 32'(count), 32'd8);
    chk("t3_ovf", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain", 32'(out_tag), 32'(8'h11 + i));
      step();
    end
    out_ready = 1'b0;
    chk("t3_empty", 32'(empty), 32'd1);
    chk("t3_rc", 32'(result_count), 32'd9);

    // continuous streaming
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      done = 1'b1;
      InsTagDescale = 8'(i);
      if (i == 0) begin
        chk("t4_first", 32'(out_valid), 32'd0);
      end else begin
        chk("t4_tag", 32'(out_tag), 32'(i - 1));
        chk("t4_count", 32'(count), 32'd1);
      end
      step();
    end
    done = 1'b0;
    chk("t4_tail", 32'(out_tag), 32'd19);
    chk("t4_rc19", 32'(result_count), 32'd19);
    step();
    out_ready = 1'b0;
    chk("t4_rc20", 32'(result_count), 32'd20);
    chk("t4_empty", 32'(empty), 32'd1);

    // flush keeps overflow and result_count
    for (int i = 0; i < 9; i++) begin
      done = 1'b1;
      InsTagDescale = 8'(8'h20 + i);
      step();
    end
    done = 1'b0;
    chk("t5_ovf", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    step();
    step();
    step();
    out_ready = 1'b0;
    chk("t5_count5", 32'(count), 32'd5);
    chk("t5_head", 32'(out_tag), 32'h23);
    chk("t5_rc", 32'(result_count), 32'd23);
    flush = 1'b1;
    done = 1'b1;
    out_ready = 1'b1;
    InsTagDescale = 8'h77;
    step();
    flush = 1'b0;
    done = 1'b0;
    out_ready = 1'b0;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_rc_keep", 32'(result_count), 32'd23);
    chk("t5_ovf_keep", 32'(overflow), 32'd1);

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      done = 1'b1;
      InsTagDescale = 8'(8'h30 + i);
      step();
    end
    done = 1'b0;
    chk("t6_count3", 32'(count), 32'd3);
    chk("t6_head", 32'(out_tag), 32'h30);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_rc", 32'(result_count), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_tag", 32'(out_tag), 32'd0);
    done = 1'b1;
    step();
    chk("t6_ignored", 32'(count), 32'd0);
    done = 1'b0;
    reset = 1'b1;
    step();
    chk("t6_after", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
